axi_lite_master_arbiter: RTL and testbench

//  Shares one AXI4-Lite master port among NUM_REQ local requesters (register-config engines).
//  - Each requester issues single-beat read/write commands on a simple valid/ready port.
//  - The block grants one requester at a time and sequences the full AW/W/B or AR/R handshake.
//  - The response is returned only to the granted requester.
//  - Sits between the control engines and the tvip_axi_lite_if master side.

---
 rtl/tvip_axi_lite_types_pkg.sv | 21 ++
 rtl/axi_lite_master_arbiter_if.sv | 35 +++
 rtl/axi_lite_rr_grant.sv | 51 +++++
 rtl/axi_lite_master_arbiter.sv | 145 ++++++++++++++
 tb/tb_axi_lite_master_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tvip_axi_lite_types_pkg.sv
// Shared AXI4-Lite types and constants for the master-port arbiter.
package tvip_axi_lite_types_pkg;

  typedef enum logic [1:0] {
    TVIP_AXI_OKAY   = 2'b00,
    TVIP_AXI_EXOKAY = 2'b01,
    TVIP_AXI_SLVERR = 2'b10,
    TVIP_AXI_DECERR = 2'b11
  } tvip_axi_response;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4
  } arb_state_e;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_master_arbiter_if.sv
// AXI4-Lite master-side bus bundle; master modport faces the arbiter, slave modport faces the fabric.
interface axi_lite_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi_lite_rr_grant.sv
// Request vector + search start -> one-hot grant and index.
// AXI_LITE_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module axi_lite_rr_grant #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) idx = IDX_W'(k);
    end
  end
`else
  logic [IDX_W:0] cand;
  logic           found;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N)) cand = cand - (IDX_W + 1)'(N);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end
`endif

  assign any = |req;

  always_comb begin
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/axi_lite_master_arbiter.sv
// Shares one AXI4-Lite master port among NUM_REQ single-beat requesters.
// Define AXI_LITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority (round-robin otherwise).
module axi_lite_master_arbiter
  import tvip_axi_lite_types_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESETN,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [1:0]                  rsp_resp,
  axi_lite_master_arbiter_if.master   m_axi
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IDX_W-1:0]   gnt_idx, start_idx, sel_q;
  logic               gnt_any, grant_now;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [STRB_W-1:0]  wstrb_q;
  logic               awvalid_q, wvalid_q;
  logic               aw_ok, w_ok, b_hs, r_hs;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
  logic [STRB_W-1:0]  wstrb_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    assign wstrb_arr[i] = req_wstrb[i*STRB_W +: STRB_W];
  end

  axi_lite_rr_grant #(.N(NUM_REQ), .IDX_W(IDX_W)) u_grant (
    .req   (req_valid),
    .ptr   (start_idx),
    .grant (gnt_onehot),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign grant_now = (state_q == IDLE) && gnt_any;

`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  // Pointer holds where the next search starts: one past the last winner.
  logic [IDX_W-1:0] rr_ptr_q;
  assign start_idx = rr_ptr_q;

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN)   rr_ptr_q <= '0;
    else if (grant_now) rr_ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end
`endif

  assign aw_ok = !awvalid_q || m_axi.awready;
  assign w_ok  = !wvalid_q  || m_axi.wready;
  assign b_hs  = (state_q == WR_B) && m_axi.bvalid;
  assign r_hs  = (state_q == RD_R) && m_axi.rvalid;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_any) state_d = req_write[gnt_idx] ? WR_AW_W : RD_AR;
      WR_AW_W: if (aw_ok && w_ok) state_d = WR_B;
      WR_B:    if (b_hs) state_d = IDLE;
      RD_AR:   if (m_axi.arready) state_d = RD_R;
      RD_R:    if (r_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      if (grant_now) begin
        req_ready <= gnt_onehot;
        sel_q     <= gnt_idx;
        addr_q    <= addr_arr[gnt_idx];
        wdata_q   <= wdata_arr[gnt_idx];
        wstrb_q   <= wstrb_arr[gnt_idx];
        awvalid_q <= req_write[gnt_idx];
        wvalid_q  <= req_write[gnt_idx];
      end
      // AW and W retire independently; the state leaves only once both are gone.
      if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
      if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
      if (b_hs) begin
        rsp_valid <= NUM_REQ'(1) << sel_q;
        rsp_rdata <= '0;
        rsp_resp  <= m_axi.bresp;
      end
      if (r_hs) begin
        rsp_valid <= NUM_REQ'(1) << sel_q;
        rsp_rdata <= m_axi.rdata;
        rsp_resp  <= m_axi.rresp;
      end
    end
  end

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = AXI_PROT_DEFAULT;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.bready  = (state_q == WR_B);
  assign m_axi.arvalid = (state_q == RD_AR);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = AXI_PROT_DEFAULT;
  assign m_axi.rready  = (state_q == RD_R);

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Directed bench: responsive AXI4-Lite slave model plus a response scoreboard.
module tb_axi_lite_master_arbiter;
  import tvip_axi_lite_types_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        req_valid = '0, req_ready, req_write = '0, rsp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ*STRB_W-1:0] req_wstrb = '0;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [1:0]                rsp_resp;

  axi_lite_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi_lite_master_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .AXI_ACLK    (clk),
    .AXI_ARESETN (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .m_axi       (axi.master)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard of expected responses, in grant order
  typedef struct packed {
    logic [NUM_REQ-1:0] onehot;
    logic [DATA_W-1:0]  rdata;
    logic [1:0]         resp;
  } exp_t;
  exp_t               exp_q[$];
  logic [NUM_REQ-1:0] grant_log[$];
  int                 rsp_cnt = 0;

  // Slave configuration and observations
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0;

  // Slave: handshakes sampled mid-cycle, ready/valid updates driven just after the edge
  initial begin
    logic hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_got, w_got, pend_b, pend_r;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid} = '0;
    axi.bresp = '0; axi.rresp = '0; axi.rdata = '0;
    {aw_got, w_got, pend_b, pend_r} = '0;
    {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
    forever begin
      @(negedge clk);
      hs_aw = axi.awvalid && axi.awready;
      hs_w  = axi.wvalid && axi.wready;
      hs_b  = axi.bvalid && axi.bready;
      hs_ar = axi.arvalid && axi.arready;
      hs_r  = axi.rvalid && axi.rready;
      if (hs_aw) begin aw_hs_cnt++; cap_awaddr = axi.awaddr; end
      if (hs_w)  begin w_hs_cnt++; cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; end
      if (hs_b)  b_hs_cnt++;
      if (hs_ar) cap_araddr = axi.araddr;
      @(posedge clk);
      #2;
      if (!rst_n) begin
        {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid} = '0;
        {aw_got, w_got, pend_b, pend_r} = '0;
        {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
      end else begin
        if (hs_aw) begin axi.awready = 1'b0; aw_got = 1'b1; aw_wait = 0; end
        else if (axi.awvalid && !axi.awready) begin
          if (aw_wait >= aw_delay) axi.awready = 1'b1; else aw_wait++;
        end
        if (hs_w) begin axi.wready = 1'b0; w_got = 1'b1; w_wait = 0; end
        else if (axi.wvalid && !axi.wready) begin
          if (w_wait >= w_delay) axi.wready = 1'b1; else w_wait++;
        end
        if (aw_got && w_got) begin aw_got = 1'b0; w_got = 1'b0; pend_b = 1'b1; b_wait = 0; end
        if (hs_b) begin axi.bvalid = 1'b0; pend_b = 1'b0; end
        else if (pend_b && !axi.bvalid) begin
          if (b_wait >= b_delay) begin axi.bvalid = 1'b1; axi.bresp = b_resp_cfg; end
          else b_wait++;
        end
        if (hs_ar) begin axi.arready = 1'b0; ar_wait = 0; pend_r = 1'b1; r_wait = 0; end
        else if (axi.arvalid && !axi.arready) begin
          if (ar_wait >= ar_delay) axi.arready = 1'b1; else ar_wait++;
        end
        if (hs_r) begin axi.rvalid = 1'b0; pend_r = 1'b0; end
        else if (pend_r && !axi.rvalid) begin
          if (r_wait >= r_delay) begin axi.rvalid = 1'b1; axi.rdata = r_data_cfg; axi.rresp = r_resp_cfg; end
          else r_wait++;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every response pulse, logs grants
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req_ready !== '0) grant_log.push_back(req_ready);
      if (rsp_valid !== '0) begin
        rsp_cnt++;
        if (exp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("rsp_valid", 64'(rsp_valid), 64'(e.onehot));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_resp",  64'(rsp_resp),  64'(e.resp));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_rsp(input int i, input logic [31:0] rdata, input logic [1:0] resp);
    exp_t e;
    e.onehot = NUM_REQ'(1) << i;
    e.rdata  = rdata;
    e.resp   = resp;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int i, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    req_write[i] = wr;
    req_addr[i*ADDR_W +: ADDR_W]  = addr;
    req_wdata[i*DATA_W +: DATA_W] = data;
    req_wstrb[i*STRB_W +: STRB_W] = strb;
    req_valid[i] = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!req_ready[i] && n < 50);
    req_valid[i] = 1'b0;
    check("grant_seen", 64'(req_ready[i]), 64'(1));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    check(tag, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int aw0, w0, b0, n_g, n, rsp0;
    logic [NUM_REQ-1:0] exp_gnt [5];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid}), 64'(0));
    check("rst_readies", 64'({axi.bready, axi.rready}), 64'(0));
    check("rst_rsp_data", 64'({rsp_rdata, rsp_resp}), 64'(0));
    check("prot", 64'({axi.awprot, axi.arprot}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single write from requester 0
    b_resp_cfg = 2'b00;
    expect_rsp(0, 32'h0, 2'b00);
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    drain("t1_drain");
    check("t1_awaddr", 64'(cap_awaddr), 64'h10);
    check("t1_wdata", 64'(cap_wdata), 64'hDEADBEEF);
    check("t1_wstrb", 64'(cap_wstrb), 64'hF);

    // 2: single read from requester 2
    r_data_cfg = 32'h12345678; r_resp_cfg = 2'b00;
    expect_rsp(2, 32'h12345678, 2'b00);
    issue(2, 1'b0, 32'h20, 32'h0, 4'h0);
    drain("t2_drain");
    check("t2_araddr", 64'(cap_araddr), 64'h20);

    // 3: all four requesting continuously from a fresh pointer
    do_reset();
`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
    exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    grant_log.delete();
    r_data_cfg = 32'hA5A50003;
    for (int k = 0; k < 5; k++) begin
      exp_t e;
      e.onehot = exp_gnt[k]; e.rdata = 32'hA5A50003; e.resp = 2'b00;
      exp_q.push_back(e);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_write[i] = 1'b0;
      req_addr[i*ADDR_W +: ADDR_W] = 32'h100 + 32'(i * 4);
    end
    req_valid = '1;
    n_g = 0; n = 0;
    while (n_g < 5 && n < 300) begin
      @(posedge clk); #1; n++;
      if (req_ready !== '0) n_g++;
      if (n_g == 5) req_valid = '0;
    end
    req_valid = '0;
    drain("t3_drain");
    check("t3_grant_cnt", 64'(grant_log.size()), 64'(5));
    for (int k = 0; k < 5; k++) check($sformatf("t3_grant%0d", k), 64'(grant_log[k]), 64'(exp_gnt[k]));

    // 4: AW/W ready skew both ways and aligned; last one returns DECERR
    for (int k = 0; k < 3; k++) begin
      aw_delay = (k == 1) ? 3 : 0;
      w_delay  = (k == 0) ? 3 : 0;
      b_resp_cfg = (k == 2) ? 2'b11 : 2'b00;
      aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
      expect_rsp(3 - k, 32'h0, b_resp_cfg);
      issue(3 - k, 1'b1, 32'h40 + 32'(k * 4), 32'hC0DE0000 + 32'(k), 4'(1 << k));
      drain($sformatf("t4_drain%0d", k));
      check($sformatf("t4_aw_cnt%0d", k), 64'(aw_hs_cnt - aw0), 64'(1));
      check($sformatf("t4_w_cnt%0d", k),  64'(w_hs_cnt - w0),   64'(1));
      check($sformatf("t4_b_cnt%0d", k),  64'(b_hs_cnt - b0),   64'(1));
      check($sformatf("t4_wdata%0d", k),  64'(cap_wdata), 64'(32'hC0DE0000 + 32'(k)));
      check($sformatf("t4_awaddr%0d", k), 64'(cap_awaddr), 64'(32'h40 + 32'(k * 4)));
    end
    aw_delay = 0; w_delay = 0; b_resp_cfg = 2'b00;

    // 5: SLVERR on a read, delivered to requester 1 only
    r_data_cfg = 32'hBAD0BAD0; r_resp_cfg = 2'b10; r_delay = 2; ar_delay = 1;
    expect_rsp(1, 32'hBAD0BAD0, 2'b10);
    issue(1, 1'b0, 32'h30, 32'h0, 4'h0);
    drain("t5_drain");
    r_resp_cfg = 2'b00; r_delay = 0; ar_delay = 0;

    // 6: reset while waiting for B; the write is dropped silently
    b_delay = 20;
    issue(0, 1'b1, 32'h50, 32'h11112222, 4'hF);
    n = 0;
    while (!axi.bready && n < 20) begin @(posedge clk); #1; n++; end
    check("t6_in_wr_b", 64'(axi.bready), 64'(1));
    rsp0 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_rsp_valid", 64'(rsp_valid), 64'(0));
    check("t6_bus_out", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'(0));
    check("t6_req_ready", 64'(req_ready), 64'(0));
    check("t6_rsp_data", 64'({rsp_rdata, rsp_resp}), 64'(0));
    check("t6_state", 64'(dut.state_q), 64'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b_delay = 0;
    repeat (30) @(posedge clk);
    #1;
    check("t6_no_rsp", 64'(rsp_cnt - rsp0), 64'(0));

    // Recovery after reset
    r_data_cfg = 32'h0F0F0F0F;
    expect_rsp(3, 32'h0F0F0F0F, 2'b00);
    issue(3, 1'b0, 32'h3C, 32'h0, 4'h0);
    drain("t6_recover");
    check("t6_rec_araddr", 64'(cap_araddr), 64'h3C);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
